// File: rtl/stopwatch_core_bcd_if.sv
// Control pulses in, BCD time and status out, for the stopwatch core.
// Board logic drives the master side and the core uses the slave side.
interface stopwatch_core_bcd_if;
  logic        i_start_stop;
  logic        i_lap;
  logic        i_clear;
  logic [19:0] o_digits;
  logic        o_running;
  logic        o_frozen;
  logic        o_tick;
  logic        o_overflow;
  logic        o_blink;

  modport master (
    output i_start_stop, i_lap, i_clear,
    input  o_digits, o_running, o_frozen, o_tick, o_overflow, o_blink
  );

  modport slave (
    input  i_start_stop, i_lap, i_clear,
    output o_digits, o_running, o_frozen, o_tick, o_overflow, o_blink
  );
endinterface

// File: rtl/stopwatch_core_bcd.sv
// Single-clock MM:SS.t stopwatch: a prescaler produces a clock enable, and that enable steps a BCD digit chain.
// State | meaning: STOPPED = prescaler and digits hold; RUNNING = prescaler counts and ticks advance the digits.
module stopwatch_core_bcd #(
  parameter int DIV          = 50_000_000 / 10,
  parameter int MIN_TENS_MOD = 10
) (
  input logic                 i_clk,
  input logic                 i_reset_n,
  stopwatch_core_bcd_if.slave bus
);
  localparam int            PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);
  localparam logic [3:0]    M10_MAX  = 4'(MIN_TENS_MOD - 1);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} run_state_e;

  run_state_e    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    t_q, t_d, s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
  logic [19:0]   snap_q, snap_d;
  logic          frozen_q, frozen_d, ovf_q, ovf_d, tick_q, tick_d;
  logic          tick, c_t, c_s1, c_s10, c_m1, c_m10;
  logic [19:0]   live;

  assign live = {m10_q, m1_q, s10_q, s1_q, t_q};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= STOPPED;
      presc_q  <= '0;
      t_q      <= '0;
      s1_q     <= '0;
      s10_q    <= '0;
      m1_q     <= '0;
      m10_q    <= '0;
      snap_q   <= '0;
      frozen_q <= 1'b0;
      ovf_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      t_q      <= t_d;
      s1_q     <= s1_d;
      s10_q    <= s10_d;
      m1_q     <= m1_d;
      m10_q    <= m10_d;
      snap_q   <= snap_d;
      frozen_q <= frozen_d;
      ovf_q    <= ovf_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    t_d      = t_q;
    s1_d     = s1_q;
    s10_d    = s10_q;
    m1_d     = m1_q;
    m10_d    = m10_q;
    snap_d   = snap_q;
    frozen_d = frozen_q;
    ovf_d    = ovf_q;
    tick_d   = 1'b0;
    c_t      = 1'b0;
    c_s1     = 1'b0;
    c_s10    = 1'b0;
    c_m1     = 1'b0;
    c_m10    = 1'b0;
    // Tick comes from the pre-edge state, so a stop pulse on a terminal count still lets it through.
    tick     = (state_q == RUNNING) && (presc_q == PRESC_TC);

    if (bus.i_start_stop) begin
      case (state_q)
        STOPPED: state_d = RUNNING;
        default: state_d = STOPPED;
      endcase
    end

    if (bus.i_clear) begin
      presc_d  = '0;
      t_d      = '0;
      s1_d     = '0;
      s10_d    = '0;
      m1_d     = '0;
      m10_d    = '0;
      snap_d   = '0;
      frozen_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (state_q == RUNNING) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        tick_d = 1'b1;
        c_t    = (t_q == 4'd9);
        t_d    = c_t ? 4'd0 : t_q + 4'd1;
        if (c_t) begin
          c_s1 = (s1_q == 4'd9);
          s1_d = c_s1 ? 4'd0 : s1_q + 4'd1;
        end
        if (c_s1) begin
          c_s10 = (s10_q == 4'd5);
          s10_d = c_s10 ? 4'd0 : s10_q + 4'd1;
        end
        if (c_s10) begin
          c_m1 = (m1_q == 4'd9);
          m1_d = c_m1 ? 4'd0 : m1_q + 4'd1;
        end
        if (c_m1) begin
          c_m10 = (m10_q == M10_MAX);
          m10_d = c_m10 ? 4'd0 : m10_q + 4'd1;
        end
        if (c_m10) ovf_d = 1'b1;
      end
      // Lap sees the running state after this cycle's start/stop toggle.
      if (bus.i_lap) begin
        if (frozen_q) begin
          frozen_d = 1'b0;
        end else if (state_d == RUNNING) begin
          frozen_d = 1'b1;
          snap_d   = live;
        end
      end
    end
  end

  assign bus.o_digits   = frozen_q ? snap_q : live;
  assign bus.o_running  = (state_q == RUNNING);
  assign bus.o_frozen   = frozen_q;
  assign bus.o_tick     = tick_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_blink    = (t_q < 4'd5);
endmodule

// File: tb/tb_stopwatch_core_bcd.sv
// Directed bench: one core at DIV=4/MIN_TENS_MOD=10 for timing, lap, clear and reset,
// and one at DIV=2/MIN_TENS_MOD=3 for the wrap-around overflow, both run in parallel.
module tb_stopwatch_core_bcd;
  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  stopwatch_core_bcd_if if_a ();
  stopwatch_core_bcd_if if_b ();

  stopwatch_core_bcd #(.DIV(4), .MIN_TENS_MOD(10)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n_a), .bus(if_a.slave)
  );
  stopwatch_core_bcd #(.DIV(2), .MIN_TENS_MOD(3)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n_b), .bus(if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_a(input logic ss, input logic lap, input logic clr);
    if_a.i_start_stop = ss;
    if_a.i_lap        = lap;
    if_a.i_clear      = clr;
    step(1);
    if_a.i_start_stop = 1'b0;
    if_a.i_lap        = 1'b0;
    if_a.i_clear      = 1'b0;
  endtask

  task automatic press_b(input logic ss, input logic clr);
    if_b.i_start_stop = ss;
    if_b.i_clear      = clr;
    step(1);
    if_b.i_start_stop = 1'b0;
    if_b.i_clear      = 1'b0;
  endtask

  task automatic run_a();
    int ticks;
    rst_n_a = 1'b0;
    step(2);
    check("rst_digits", if_a.o_digits, 32'h0);
    check("rst_running", if_a.o_running, 32'h0);
    check("rst_frozen", if_a.o_frozen, 32'h0);
    check("rst_tick", if_a.o_tick, 32'h0);
    check("rst_ovf", if_a.o_overflow, 32'h0);
    check("rst_blink", if_a.o_blink, 32'h1);
    rst_n_a = 1'b1;

    press_a(1'b1, 1'b0, 1'b0);
    check("start_running", if_a.o_running, 32'h1);
    ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (if_a.o_tick) ticks++;
      if (i == 4)  check("first_tick", if_a.o_tick, 32'h1);
      if (i == 19) check("blink_t4", if_a.o_blink, 32'h1);
      if (i == 20) check("blink_t5", if_a.o_blink, 32'h0);
      if (i == 40) check("blink_t0", if_a.o_blink, 32'h1);
    end
    check("ticks_40", ticks, 32'd10);
    check("digits_1s", if_a.o_digits, 32'h00010);

    // Stop with a partial tick accumulated, idle, then resume.
    press_a(1'b0, 1'b0, 1'b1);
    check("clr_digits", if_a.o_digits, 32'h0);
    check("clr_running", if_a.o_running, 32'h1);
    step(9);
    press_a(1'b1, 1'b0, 1'b0);
    check("stop_running", if_a.o_running, 32'h0);
    check("stop_digits", if_a.o_digits, 32'h00002);
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (if_a.o_tick) ticks++;
    end
    check("idle_ticks", ticks, 32'd0);
    check("idle_digits", if_a.o_digits, 32'h00002);
    press_a(1'b1, 1'b0, 1'b0);
    check("resume_tick0", if_a.o_tick, 32'h0);
    step(1);
    check("resume_tick1", if_a.o_tick, 32'h0);
    step(1);
    check("resume_tick2", if_a.o_tick, 32'h1);
    check("resume_digits", if_a.o_digits, 32'h00003);

    // Lap freeze while live count keeps going.
    press_a(1'b0, 1'b0, 1'b1);
    step(48);
    check("lap_pre", if_a.o_digits, 32'h00012);
    press_a(1'b0, 1'b1, 1'b0);
    check("lap_frozen", if_a.o_frozen, 32'h1);
    check("lap_digits", if_a.o_digits, 32'h00012);
    step(19);
    check("lap_hold", if_a.o_digits, 32'h00012);
    check("lap_blink_live", if_a.o_blink, 32'h0);
    step(12);
    check("lap_hold2", if_a.o_digits, 32'h00012);
    press_a(1'b0, 1'b1, 1'b0);
    check("unlap_frozen", if_a.o_frozen, 32'h0);
    check("unlap_digits", if_a.o_digits, 32'h00020);

    // Clear and stop in the same cycle.
    press_a(1'b0, 1'b0, 1'b1);
    step(136);
    check("pre_cs_digits", if_a.o_digits, 32'h00034);
    press_a(1'b1, 1'b0, 1'b1);
    check("cs_digits", if_a.o_digits, 32'h0);
    check("cs_running", if_a.o_running, 32'h0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (if_a.o_tick) ticks++;
    end
    check("cs_ticks", ticks, 32'd0);
    press_a(1'b0, 1'b1, 1'b0);
    check("stopped_lap", if_a.o_frozen, 32'h0);

    // Reset mid-count while frozen.
    press_a(1'b1, 1'b0, 1'b0);
    step(30180);
    check("long_digits", if_a.o_digits, 32'h12345);
    press_a(1'b0, 1'b1, 1'b0);
    check("long_frozen", if_a.o_frozen, 32'h1);
    rst_n_a = 1'b0;
    if_a.i_start_stop = 1'b1;
    if_a.i_lap        = 1'b1;
    if_a.i_clear      = 1'b1;
    step(1);
    check("mrst_digits", if_a.o_digits, 32'h0);
    check("mrst_running", if_a.o_running, 32'h0);
    check("mrst_frozen", if_a.o_frozen, 32'h0);
    check("mrst_blink", if_a.o_blink, 32'h1);
    step(3);
    check("mrst_hold_run", if_a.o_running, 32'h0);
    if_a.i_start_stop = 1'b0;
    if_a.i_lap        = 1'b0;
    if_a.i_clear      = 1'b0;
    rst_n_a = 1'b1;
    step(10);
    check("post_rst_run", if_a.o_running, 32'h0);
    check("post_rst_dig", if_a.o_digits, 32'h0);
  endtask

  task automatic run_b();
    rst_n_b = 1'b0;
    step(2);
    check("b_rst_digits", if_b.o_digits, 32'h0);
    rst_n_b = 1'b1;
    press_b(1'b1, 1'b0);
    step(1198);
    check("b_0599", if_b.o_digits, 32'h00599);
    step(2);
    check("b_1000", if_b.o_digits, 32'h01000);
    step(34798);
    check("b_max", if_b.o_digits, 32'h29599);
    check("b_max_ovf", if_b.o_overflow, 32'h0);
    step(1);
    check("b_max_hold", if_b.o_digits, 32'h29599);
    step(1);
    check("b_wrap_dig", if_b.o_digits, 32'h0);
    check("b_wrap_ovf", if_b.o_overflow, 32'h1);
    check("b_wrap_tick", if_b.o_tick, 32'h1);
    step(2);
    check("b_cont_dig", if_b.o_digits, 32'h00001);
    check("b_cont_ovf", if_b.o_overflow, 32'h1);
    press_b(1'b0, 1'b1);
    check("b_clr_ovf", if_b.o_overflow, 32'h0);
    check("b_clr_run", if_b.o_running, 32'h1);
    check("b_clr_dig", if_b.o_digits, 32'h0);
  endtask

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    if_a.i_start_stop = 1'b0;
    if_a.i_lap        = 1'b0;
    if_a.i_clear      = 1'b0;
    if_b.i_start_stop = 1'b0;
    if_b.i_lap        = 1'b0;
    if_b.i_clear      = 1'b0;
    fork
      run_a();
      run_b();
    join
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
